// File: rtl/eco32f_writeback_arb.sv
// Writeback stage: registers the memory-stage result (with load extraction) and
// arbitrates it against buffered late-unit results for the single RF write port.
module eco32f_writeback_arb #(
  parameter int unsigned NUM_LATE      = 2,
  parameter int unsigned RF_ADDR_WIDTH = 5,
  parameter int unsigned BIG_ENDIAN    = 1,
  parameter int unsigned DISCARD_R0    = 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              mem_stall,
  input  logic                              mem_valid,
  input  logic [31:0]                       mem_alu_result,
  input  logic [31:0]                       mem_lsu_result,
  input  logic                              mem_op_load,
  input  logic [1:0]                        mem_load_size,
  input  logic                              mem_load_signed,
  input  logic [1:0]                        mem_load_addr_lo,
  input  logic                              mem_rf_r_we,
  input  logic [RF_ADDR_WIDTH-1:0]          mem_rf_r_addr,
  input  logic [NUM_LATE-1:0]               late_valid,
  input  logic [32*NUM_LATE-1:0]            late_result,
  input  logic [RF_ADDR_WIDTH*NUM_LATE-1:0] late_addr,
  output logic [NUM_LATE-1:0]               late_ready,
  output logic [NUM_LATE-1:0]               late_pending,
  output logic [31:0]                       wb_rf_r,
  output logic                              wb_rf_r_we,
  output logic [RF_ADDR_WIDTH-1:0]          wb_rf_r_addr
);

  logic                     pipe_valid_reg;
  logic [RF_ADDR_WIDTH-1:0] pipe_addr_reg;
  logic [31:0]              pipe_data_reg;

  logic [NUM_LATE-1:0]      buf_valid_reg;
  logic [RF_ADDR_WIDTH-1:0] buf_addr_reg [NUM_LATE];
  logic [31:0]              buf_data_reg [NUM_LATE];

  logic [NUM_LATE-1:0]      late_drop;
  logic [NUM_LATE-1:0]      squash;
  logic [NUM_LATE-1:0]      drain;
  logic [RF_ADDR_WIDTH-1:0] sel_addr;
  logic [31:0]              sel_data;
  logic                     found;

  logic [1:0]  byte_lane;
  logic        half_lane;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] pipe_data_next;
  logic        pipe_drop;

  // Lane numbering is flipped for big-endian so offset 0 maps to the top bits.
  always_comb begin
    byte_lane = (BIG_ENDIAN != 0) ? ~mem_load_addr_lo : mem_load_addr_lo;
    half_lane = (BIG_ENDIAN != 0) ? ~mem_load_addr_lo[1] : mem_load_addr_lo[1];
    byte_sel  = 8'(mem_lsu_result >> {byte_lane, 3'b000});
    half_sel  = 16'(mem_lsu_result >> {half_lane, 4'b0000});
    pipe_data_next = mem_alu_result;
    if (mem_op_load) begin
      case (mem_load_size)
        2'b00:   pipe_data_next = {{24{mem_load_signed & byte_sel[7]}}, byte_sel};
        2'b01:   pipe_data_next = {{16{mem_load_signed & half_sel[15]}}, half_sel};
        default: pipe_data_next = mem_lsu_result;
      endcase
    end
  end

  assign pipe_drop = (DISCARD_R0 != 0) && (mem_rf_r_addr == '0);

  // A stalled memory stage must not re-issue the same write, so valid drops.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pipe_valid_reg <= 1'b0;
      pipe_addr_reg  <= '0;
      pipe_data_reg  <= '0;
    end else if (!mem_stall) begin
      pipe_valid_reg <= mem_valid & mem_rf_r_we & ~pipe_drop;
      pipe_addr_reg  <= mem_rf_r_addr;
      pipe_data_reg  <= pipe_data_next;
    end else begin
      pipe_valid_reg <= 1'b0;
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_LATE; gi++) begin : g_chan
      assign late_drop[gi] = (DISCARD_R0 != 0) &&
                             (late_addr[RF_ADDR_WIDTH*gi +: RF_ADDR_WIDTH] == '0);
      // Late results are older than the pipeline write, so a matching one is dead.
      assign squash[gi]    = pipe_valid_reg && buf_valid_reg[gi] &&
                             (buf_addr_reg[gi] == pipe_addr_reg);
    end
  endgenerate

  always_comb begin
    drain    = '0;
    found    = 1'b0;
    sel_addr = pipe_addr_reg;
    sel_data = pipe_data_reg;
    if (!pipe_valid_reg) begin
      for (int i = 0; i < NUM_LATE; i++) begin
        if (buf_valid_reg[i] && !found) begin
          found    = 1'b1;
          drain[i] = 1'b1;
          sel_addr = buf_addr_reg[i];
          sel_data = buf_data_reg[i];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      buf_valid_reg <= '0;
      for (int i = 0; i < NUM_LATE; i++) begin
        buf_addr_reg[i] <= '0;
        buf_data_reg[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_LATE; i++) begin
        if (late_valid[i] && !buf_valid_reg[i]) begin
          buf_valid_reg[i] <= ~late_drop[i];
          buf_addr_reg[i]  <= late_addr[RF_ADDR_WIDTH*i +: RF_ADDR_WIDTH];
          buf_data_reg[i]  <= late_result[32*i +: 32];
        end else if (drain[i] || squash[i]) begin
          buf_valid_reg[i] <= 1'b0;
        end
      end
    end
  end

  assign late_ready   = ~buf_valid_reg;
  assign late_pending = buf_valid_reg;
  assign wb_rf_r_we   = pipe_valid_reg | (|buf_valid_reg);
  assign wb_rf_r      = sel_data;
  assign wb_rf_r_addr = sel_addr;

endmodule

// File: tb/tb_eco32f_writeback_arb.sv
// Bench for eco32f_writeback_arb: directed scenarios plus a randomized run
// checked against a behavioural model of the writeback/late-buffer rules.
module tb_eco32f_writeback_arb;
  localparam int NL = 2;
  localparam int AW = 5;
  localparam int BE = 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          mem_stall, mem_valid, mem_op_load, mem_load_signed, mem_rf_r_we;
  logic [31:0]   mem_alu_result, mem_lsu_result;
  logic [1:0]    mem_load_size, mem_load_addr_lo;
  logic [AW-1:0] mem_rf_r_addr;
  logic [NL-1:0] late_valid, late_ready, late_pending;
  logic [32*NL-1:0] late_result;
  logic [AW*NL-1:0] late_addr;
  logic [31:0]   wb_rf_r;
  logic          wb_rf_r_we;
  logic [AW-1:0] wb_rf_r_addr;

  int pass_cnt = 0;
  int total_cnt = 0;

  // Reference model state
  bit          m_pv = 0;
  int unsigned m_pa = 0;
  logic [31:0] m_pd = 0;
  bit          m_bv [NL];
  int unsigned m_ba [NL];
  logic [31:0] m_bd [NL];
  bit          e_we;
  int unsigned e_addr;
  logic [31:0] e_data;
  logic [NL-1:0] e_pend;

  always #5 clk = ~clk;

  eco32f_writeback_arb #(.NUM_LATE(NL), .RF_ADDR_WIDTH(AW), .BIG_ENDIAN(BE), .DISCARD_R0(1)) dut (
    .clk(clk), .rst(rst), .mem_stall(mem_stall), .mem_valid(mem_valid),
    .mem_alu_result(mem_alu_result), .mem_lsu_result(mem_lsu_result),
    .mem_op_load(mem_op_load), .mem_load_size(mem_load_size),
    .mem_load_signed(mem_load_signed), .mem_load_addr_lo(mem_load_addr_lo),
    .mem_rf_r_we(mem_rf_r_we), .mem_rf_r_addr(mem_rf_r_addr),
    .late_valid(late_valid), .late_result(late_result), .late_addr(late_addr),
    .late_ready(late_ready), .late_pending(late_pending),
    .wb_rf_r(wb_rf_r), .wb_rf_r_we(wb_rf_r_we), .wb_rf_r_addr(wb_rf_r_addr)
  );

  // Byte at memory offset k of the bus word, then assembled arithmetically.
  function automatic logic [31:0] ref_extract(bit ld, int size, bit sgn, int lo,
                                              logic [31:0] alu, logic [31:0] lsu);
    longint b [4];
    longint v;
    int w;
    if (!ld) return alu;
    for (int k = 0; k < 4; k++)
      b[k] = (BE != 0) ? ((lsu >> (8 * (3 - k))) & 255) : ((lsu >> (8 * k)) & 255);
    if (size == 0) begin
      v = b[lo]; w = 8;
    end else if (size == 1) begin
      v = (BE != 0) ? b[lo & 2] * 256 + b[(lo & 2) + 1] : b[(lo & 2) + 1] * 256 + b[lo & 2];
      w = 16;
    end else begin
      return lsu;
    end
    if (sgn && v >= (longint'(1) << (w - 1))) v = v - (longint'(1) << w);
    return 32'(v);
  endfunction

  task automatic model_edge();
    bit old_bv [NL];
    bit done;
    if (!rst) begin
      m_pv = 0; m_pa = 0; m_pd = 0;
      for (int i = 0; i < NL; i++) begin m_bv[i] = 0; m_ba[i] = 0; m_bd[i] = 0; end
      return;
    end
    old_bv = m_bv;
    done = 0;
    for (int i = 0; i < NL; i++) begin
      if (m_pv && m_bv[i] && m_ba[i] == m_pa) m_bv[i] = 0;
      else if (!m_pv && m_bv[i] && !done) begin m_bv[i] = 0; done = 1; end
    end
    for (int i = 0; i < NL; i++) begin
      if (late_valid[i] && !old_bv[i] && late_addr[AW*i +: AW] != 0) begin
        m_bv[i] = 1;
        m_ba[i] = late_addr[AW*i +: AW];
        m_bd[i] = late_result[32*i +: 32];
      end
    end
    if (!mem_stall) begin
      m_pv = mem_valid && mem_rf_r_we && mem_rf_r_addr != 0;
      m_pa = mem_rf_r_addr;
      m_pd = ref_extract(mem_op_load, mem_load_size, mem_load_signed, mem_load_addr_lo,
                         mem_alu_result, mem_lsu_result);
    end else begin
      m_pv = 0;
    end
  endtask

  task automatic model_out();
    bit got;
    e_we = m_pv; e_addr = m_pa; e_data = m_pd; got = 0;
    for (int i = 0; i < NL; i++) begin
      e_pend[i] = m_bv[i];
      if (m_bv[i]) e_we = 1;
      if (!m_pv && m_bv[i] && !got) begin got = 1; e_addr = m_ba[i]; e_data = m_bd[i]; end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    mem_stall = 0; mem_valid = 0; mem_op_load = 0; mem_load_signed = 0; mem_rf_r_we = 0;
    mem_alu_result = 0; mem_lsu_result = 0; mem_load_size = 0; mem_load_addr_lo = 0;
    mem_rf_r_addr = 0; late_valid = 0; late_result = 0; late_addr = 0;
  endtask

  task automatic pipe_write(int a, logic [31:0] d);
    mem_valid = 1; mem_rf_r_we = 1; mem_op_load = 0; mem_rf_r_addr = AW'(a); mem_alu_result = d;
  endtask

  task automatic late_offer(int ch, int a, logic [31:0] d);
    late_valid[ch] = 1'b1;
    late_addr[AW*ch +: AW] = AW'(a);
    late_result[32*ch +: 32] = d;
  endtask

  task automatic test_reset();
    idle(); rst = 0; tick(); tick(); rst = 1;
    $display("reset applied");
    total_cnt++; if (wb_rf_r_we !== 1'b0) $display("FAIL reset_we: got %b want 0", wb_rf_r_we); else pass_cnt++;
    total_cnt++; if (wb_rf_r !== 32'h0) $display("FAIL reset_data: got %h want 0", wb_rf_r); else pass_cnt++;
    total_cnt++; if (wb_rf_r_addr !== 5'd0) $display("FAIL reset_addr: got %0d want 0", wb_rf_r_addr); else pass_cnt++;
    total_cnt++; if (late_ready !== 2'b11) $display("FAIL reset_ready: got %b want 11", late_ready); else pass_cnt++;
    total_cnt++; if (late_pending !== 2'b00) $display("FAIL reset_pending: got %b want 00", late_pending); else pass_cnt++;
  endtask

  task automatic test_alu_stall();
    idle(); pipe_write(3, 32'h1234_5678); tick();
    $display("alu write r3=12345678");
    total_cnt++; if (wb_rf_r_we !== 1'b1) $display("FAIL alu_we: got %b want 1", wb_rf_r_we); else pass_cnt++;
    total_cnt++; if (wb_rf_r_addr !== 5'd3) $display("FAIL alu_addr: got %0d want 3", wb_rf_r_addr); else pass_cnt++;
    total_cnt++; if (wb_rf_r !== 32'h1234_5678) $display("FAIL alu_data: got %h want 12345678", wb_rf_r); else pass_cnt++;
    mem_stall = 1;
    for (int c = 0; c < 3; c++) begin
      tick();
      total_cnt++; if (wb_rf_r_we !== 1'b0) $display("FAIL stall_we cyc%0d: got %b want 0", c, wb_rf_r_we); else pass_cnt++;
    end
    idle(); tick();
  endtask

  task automatic test_load_extract();
    logic [1:0] sz [6] = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b10, 2'b11};
    bit         sg [6] = '{1, 0, 1, 1, 1, 1};
    logic [1:0] lo [6] = '{2'd0, 2'd3, 2'd2, 2'd0, 2'd1, 2'd2};
    logic [31:0] ex [6] = '{32'hFFFF_FF80, 32'h0000_0001, 32'h0000_7F01,
                            32'hFFFF_80FF, 32'h80FF_7F01, 32'h80FF_7F01};
    idle();
    for (int k = 0; k < 6; k++) begin
      mem_valid = 1; mem_rf_r_we = 1; mem_rf_r_addr = 5'd10; mem_op_load = 1;
      mem_lsu_result = 32'h80FF_7F01; mem_alu_result = 32'hDEAD_BEEF;
      mem_load_size = sz[k]; mem_load_signed = sg[k]; mem_load_addr_lo = lo[k];
      tick();
      $display("load size=%0d signed=%0d lo=%0d -> %h", sz[k], sg[k], lo[k], wb_rf_r);
      total_cnt++;
      if (wb_rf_r_we !== 1'b1 || wb_rf_r !== ex[k])
        $display("FAIL load%0d: got we=%b data=%h want we=1 data=%h", k, wb_rf_r_we, wb_rf_r, ex[k]);
      else pass_cnt++;
    end
    idle(); tick();
  endtask

  task automatic test_late_vs_pipe();
    idle(); pipe_write(7, 32'h7777_0001); late_offer(0, 5, 32'hAAAA_AAAA); tick();
    late_valid = 0; pipe_write(7, 32'h7777_0002);
    total_cnt++; if (wb_rf_r_we !== 1'b1 || wb_rf_r_addr !== 5'd7 || wb_rf_r !== 32'h7777_0001)
      $display("FAIL lvp_c1: got we=%b r%0d=%h want r7=77770001", wb_rf_r_we, wb_rf_r_addr, wb_rf_r); else pass_cnt++;
    total_cnt++; if (late_pending[0] !== 1'b1 || late_ready[0] !== 1'b0)
      $display("FAIL lvp_pend1: got pend=%b ready=%b want 1/0", late_pending[0], late_ready[0]); else pass_cnt++;
    tick(); idle();
    total_cnt++; if (wb_rf_r_we !== 1'b1 || wb_rf_r_addr !== 5'd7 || wb_rf_r !== 32'h7777_0002)
      $display("FAIL lvp_c2: got we=%b r%0d=%h want r7=77770002", wb_rf_r_we, wb_rf_r_addr, wb_rf_r); else pass_cnt++;
    tick();
    $display("late0 drain r%0d=%h", wb_rf_r_addr, wb_rf_r);
    total_cnt++; if (wb_rf_r_we !== 1'b1 || wb_rf_r_addr !== 5'd5 || wb_rf_r !== 32'hAAAA_AAAA)
      $display("FAIL lvp_c3: got we=%b r%0d=%h want r5=aaaaaaaa", wb_rf_r_we, wb_rf_r_addr, wb_rf_r); else pass_cnt++;
    total_cnt++; if (late_pending[0] !== 1'b1) $display("FAIL lvp_pend3: got %b want 1", late_pending[0]); else pass_cnt++;
    tick();
    total_cnt++; if (wb_rf_r_we !== 1'b0 || late_pending !== 2'b00 || late_ready !== 2'b11)
      $display("FAIL lvp_c4: got we=%b pend=%b ready=%b want 0/00/11", wb_rf_r_we, late_pending, late_ready); else pass_cnt++;
  endtask

  task automatic test_priority();
    idle(); late_offer(0, 4, 32'h4444_4444); late_offer(1, 6, 32'h6666_6666); tick(); idle();
    total_cnt++; if (wb_rf_r_we !== 1'b1 || wb_rf_r_addr !== 5'd4 || wb_rf_r !== 32'h4444_4444)
      $display("FAIL prio_c1: got we=%b r%0d=%h want r4", wb_rf_r_we, wb_rf_r_addr, wb_rf_r); else pass_cnt++;
    total_cnt++; if (late_ready !== 2'b00) $display("FAIL prio_ready1: got %b want 00", late_ready); else pass_cnt++;
    tick();
    $display("prio drain r%0d=%h", wb_rf_r_addr, wb_rf_r);
    total_cnt++; if (wb_rf_r_we !== 1'b1 || wb_rf_r_addr !== 5'd6 || wb_rf_r !== 32'h6666_6666)
      $display("FAIL prio_c2: got we=%b r%0d=%h want r6", wb_rf_r_we, wb_rf_r_addr, wb_rf_r); else pass_cnt++;
    total_cnt++; if (late_ready !== 2'b01) $display("FAIL prio_ready2: got %b want 01", late_ready); else pass_cnt++;
    tick();
    total_cnt++; if (wb_rf_r_we !== 1'b0 || late_ready !== 2'b11)
      $display("FAIL prio_c3: got we=%b ready=%b want 0/11", wb_rf_r_we, late_ready); else pass_cnt++;
  endtask

  task automatic test_waw_r0();
    idle(); pipe_write(9, 32'h55); late_offer(1, 9, 32'h9999_9999); tick(); idle();
    total_cnt++; if (wb_rf_r_we !== 1'b1 || wb_rf_r_addr !== 5'd9 || wb_rf_r !== 32'h55)
      $display("FAIL waw_c1: got we=%b r%0d=%h want r9=55", wb_rf_r_we, wb_rf_r_addr, wb_rf_r); else pass_cnt++;
    total_cnt++; if (late_pending[1] !== 1'b1) $display("FAIL waw_pend1: got %b want 1", late_pending[1]); else pass_cnt++;
    for (int c = 0; c < 2; c++) begin
      tick();
      total_cnt++; if (wb_rf_r_we !== 1'b0 || late_pending !== 2'b00)
        $display("FAIL waw_after%0d: got we=%b pend=%b want 0/00", c, wb_rf_r_we, late_pending); else pass_cnt++;
    end
    pipe_write(0, 32'h1111_1111); tick(); idle();
    total_cnt++; if (wb_rf_r_we !== 1'b0) $display("FAIL r0_pipe: got we=%b want 0", wb_rf_r_we); else pass_cnt++;
    late_offer(0, 0, 32'h2222_2222); tick(); idle();
    total_cnt++; if (wb_rf_r_we !== 1'b0 || late_pending !== 2'b00 || late_ready !== 2'b11)
      $display("FAIL r0_late: got we=%b pend=%b ready=%b want 0/00/11", wb_rf_r_we, late_pending, late_ready); else pass_cnt++;
    $display("waw/r0 scenario done");
  endtask

  task automatic test_reset_mid();
    idle(); pipe_write(7, 32'h7); late_offer(0, 11, 32'hB); late_offer(1, 12, 32'hC); tick();
    pipe_write(8, 32'h8);
    total_cnt++; if (late_pending !== 2'b11) $display("FAIL rmid_pend: got %b want 11", late_pending); else pass_cnt++;
    late_offer(0, 13, 32'hD); late_offer(1, 14, 32'hE);
    rst = 0; tick(); rst = 1; idle();
    total_cnt++; if (wb_rf_r_we !== 1'b0 || late_ready !== 2'b11 || late_pending !== 2'b00)
      $display("FAIL rmid_c1: got we=%b ready=%b pend=%b want 0/11/00", wb_rf_r_we, late_ready, late_pending); else pass_cnt++;
    for (int c = 0; c < 2; c++) begin
      tick();
      total_cnt++; if (wb_rf_r_we !== 1'b0) $display("FAIL rmid_after%0d: got we=%b want 0", c, wb_rf_r_we); else pass_cnt++;
    end
    $display("mid-operation reset done");
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      mem_stall        = ($urandom_range(0, 3) == 0);
      mem_valid        = $urandom_range(0, 1);
      mem_rf_r_we      = ($urandom_range(0, 3) != 0);
      mem_rf_r_addr    = AW'($urandom_range(0, 12));
      mem_alu_result   = $urandom;
      mem_lsu_result   = $urandom;
      mem_op_load      = $urandom_range(0, 1);
      mem_load_size    = 2'($urandom_range(0, 3));
      mem_load_signed  = $urandom_range(0, 1);
      mem_load_addr_lo = 2'($urandom_range(0, 3));
      for (int i = 0; i < NL; i++) begin
        late_valid[i] = ($urandom_range(0, 2) == 0);
        late_addr[AW*i +: AW] = AW'($urandom_range(0, 12));
        late_result[32*i +: 32] = $urandom;
      end
      if (n > 390) begin mem_valid = 0; late_valid = 0; end
      tick();
      model_out();
      if (wb_rf_r_we) $display("rnd %0d write r%0d=%h", n, wb_rf_r_addr, wb_rf_r);
      total_cnt++;
      if (wb_rf_r_we !== e_we || wb_rf_r_addr !== AW'(e_addr) || wb_rf_r !== e_data)
        $display("FAIL rnd_port %0d: got we=%b r%0d=%h want we=%b r%0d=%h",
                 n, wb_rf_r_we, wb_rf_r_addr, wb_rf_r, e_we, e_addr, e_data);
      else pass_cnt++;
      total_cnt++;
      if (late_pending !== e_pend || late_ready !== ~e_pend)
        $display("FAIL rnd_flags %0d: got pend=%b ready=%b want pend=%b ready=%b",
                 n, late_pending, late_ready, e_pend, ~e_pend);
      else pass_cnt++;
    end
    idle(); tick();
  endtask

  initial begin
    for (int i = 0; i < NL; i++) begin m_bv[i] = 0; m_ba[i] = 0; m_bd[i] = 0; end
    rst = 0;
    idle();
    test_reset();
    test_alu_stall();
    test_load_extract();
    test_late_vs_pipe();
    test_priority();
    test_waw_r0();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/eco32f_writeback_arb.md
# eco32f_writeback_arb

Parametrised writeback stage with an arbitrated register-file write port. It registers the memory-stage result and performs load byte/halfword extraction with sign or zero extension. It also accepts results from NUM_LATE multi-cycle units (mul, div, …) through per-channel one-entry buffers. The block sits between the memory stage / late units and the single register-file write port, and exports per-channel pending flags for decode interlocks.

## Interface
- NUM_LATE, 2, number of late-result channels (1..8); channel 0 has highest late priority
- RF_ADDR_WIDTH, 5, register address width
- BIG_ENDIAN, 1, 1: byte offset 0 = bits [31:24]; 0: byte offset 0 = bits [7:0]
- DISCARD_R0, 1, 1: writes to register 0 are dropped (never reach buffers or port)

- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-low reset
- mem_stall  in  1  memory stage stalled; no new pipeline entry captured
- mem_valid  in  1  memory stage holds a real instruction
- mem_alu_result  in  32  ALU result
- mem_lsu_result  in  32  raw aligned bus word for loads
- mem_op_load  in  1  select load path
- mem_load_size  in  2  00 byte, 01 half, 10 word (11 treated as word)
- mem_load_signed  in  1  sign-extend byte/half
- mem_load_addr_lo  in  2  load address bits [1:0]
- mem_rf_r_we  in  1  instruction writes a register
- mem_rf_r_addr  in  RF_ADDR_WIDTH  destination
- late_valid  in  NUM_LATE  late result offered
- late_result  in  32*NUM_LATE  channel i at bits [32i+31:32i]
- late_addr  in  RF_ADDR_WIDTH*NUM_LATE  destination per channel
- late_ready  out  NUM_LATE  channel buffer empty; transfer on valid&ready
- late_pending  out  NUM_LATE  channel buffer occupied
- wb_rf_r  out  32  write data
- wb_rf_r_we  out  1  write enable
- wb_rf_r_addr  out  RF_ADDR_WIDTH  write address

## Operation
- Pipeline entry register. When mem_stall=0, the register captures pipe_valid = mem_valid & mem_rf_r_we & !(DISCARD_R0 & addr==0), plus address and the extracted result. When mem_stall=1, pipe_valid clears to 0: each instruction is written exactly once, never repeated during a stall.
- Load extraction: if mem_op_load=0, the result is mem_alu_result.
  - Word: the result is mem_lsu_result unchanged.
  - Half: lane = addr_lo[1]. BIG_ENDIAN: lane 0 = [31:16]. Little endian: lane 0 = [15:0].
  - Byte: lane = addr_lo. Lane selection follows BIG_ENDIAN the same way as half.
  - Extension: zero-extend; sign-extend if mem_load_signed. addr_lo[0] is ignored for half.
- Late buffers: channel i is captured on late_valid[i] & late_ready[i]. late_ready[i] = !buf_valid[i], registered, with no combinational path from late_valid. A channel with DISCARD_R0 and addr 0 is accepted and dropped (buffer stays empty).
- Port arbitration, combinational from registers:
  - If pipe_valid, the pipeline entry is written.
  - Otherwise the lowest-index occupied buffer is written, and that buffer clears at the edge.
  - wb_rf_r_we = pipe_valid | any buf_valid.
  - With nothing to write, wb_rf_r and wb_rf_r_addr output the pipeline register contents.
- WAW squash: in a cycle where pipe_valid writes address A, every occupied buffer with address A clears at the edge without writing. Late results are always older than the pipeline instruction.
- Simultaneous drain and capture on one channel is impossible: ready is low while the buffer is occupied.
- Pipeline writes may delay late drains indefinitely. Decode must interlock on late_pending; the block provides no starvation timer.

## Timing
- Pipeline: values captured at edge N appear on the wb_rf_r_* outputs during cycle N+1, for one cycle.
- Late: accepted at edge N, written at earliest in cycle N+1, and late_ready is high again from cycle N+2.
- Throughput: one register write per cycle in total. Each channel accepts at most one result per 2 cycles.
- Reset (rst=0 at an edge) clears:
  - pipe_valid, all buf_valid, pipeline data and address (to 0).
  - Afterwards: wb_rf_r_we=0, wb_rf_r=0, wb_rf_r_addr=0, late_ready=all 1, late_pending=all 0.
  - A reset mid-operation discards all buffered results. late_valid during reset is not captured.

## Test plan
- ALU write, stall: mem_alu_result=0x1234_5678, addr 3, stall=0, then stall=1 for 3 cycles -> exactly one cycle with we=1, addr 3, data 0x12345678; we=0 during the stall.
- Load extraction, BIG_ENDIAN=1: lsu=0x80FF_7F01.
  - Signed byte at lo=0 -> 0xFFFF_FF80; unsigned byte at lo=3 -> 0x0000_0001.
  - Signed half at lo=2 -> 0x0000_7F01; signed half at lo=0 -> 0xFFFF_80FF.
- Late vs pipeline: late0 (r5, 0xAAAA_AAAA) accepted while pipeline writes r7 for 2 consecutive cycles -> r7 written twice, then r5 in the 3rd cycle; late_pending[0] high until that edge.
- Priority: late0 (r4) and late1 (r6) accepted in the same cycle with an idle pipeline -> r4 written, then r6. late_ready[1] stays low until r6 drains.
- WAW squash and r0 discard:
  - Buffered late1 r9 while the pipeline writes r9=0x55 -> only 0x55 written; buffer cleared, with no later r9 write.
  - Pipeline write to r0 -> we stays 0.
- Reset mid-operation: both buffers occupied, rst=0 for one edge -> we=0, late_ready=all 1, no buffered writes afterwards.
